// File: rtl/life_stepper.sv
// Conway B3/S23 generation stepper on the logic side of a double-buffered grid.
// Define LIFE_WRAP_EN for a toroidal grid; otherwise cells outside the grid are dead.
module life_stepper #(
   parameter int WORD_SIZE     = 32,
   parameter int WORDS_PER_ROW = 20,
   parameter int NUM_ROWS      = 480,
   parameter int READ_LATENCY  = 2,
   parameter int LOG_MAX_ADDR  = 15
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    start_in,
   input  logic                    ready_in,
   output logic [LOG_MAX_ADDR-1:0] logic_addr_r,
   input  logic [WORD_SIZE-1:0]    logic_data_r,
   output logic [LOG_MAX_ADDR-1:0] logic_addr_w,
   output logic [WORD_SIZE-1:0]    logic_data_w,
   output logic                    logic_wr_en,
   output logic                    swap_out,
   output logic                    busy_out,
   output logic [15:0]             gen_count_out
);

   // Row and column counters are kept "extended": index 0 is the virtual row/col -1
   // and index N+1 the virtual row/col N, so the halo needs no signed arithmetic.
   localparam int ROW_W = $clog2(NUM_ROWS + 2);
   localparam int COL_W = $clog2(WORDS_PER_ROW + 2);
   localparam int PH_W  = (READ_LATENCY > 3) ? $clog2(READ_LATENCY) : 2;

   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_EDGE  = ROW_W'(NUM_ROWS + 1);
   localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WORDS_PER_ROW - 1);
   localparam logic [COL_W-1:0] COL_EDGE  = COL_W'(WORDS_PER_ROW + 1);
   localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
   localparam logic [COL_W-1:0] COL_FIRST_WR = COL_W'(2);
   localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
   localparam logic [PH_W-1:0]  PH_ISSUE_LAST = PH_W'(2);
   localparam logic [PH_W-1:0]  PH_WAIT_LAST  = PH_W'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_SWAP
   } state_t;

   // One fetch column: index 0 = row above, 1 = current row, 2 = row below.
   typedef logic [2:0][WORD_SIZE-1:0] col_t;

   state_t            r_state, w_next_state;
   logic [PH_W-1:0]   r_phase, w_next_phase;
   logic [ROW_W-1:0]  r_row,   w_next_row;
   logic [COL_W-1:0]  r_col,   w_next_col;

   logic [READ_LATENCY-1:0]       r_tag_vld;
   logic [READ_LATENCY-1:0][1:0]  r_tag_slot;
   logic                          w_cap_vld;
   logic [1:0]                    w_cap_slot;
   logic [WORD_SIZE-1:0]          w_cap_word;
   logic                          w_shift;

   logic [WORD_SIZE-1:0] r_colbuf0, r_colbuf1;
   col_t                 r_win_c, r_win_r, w_new_col;

   logic [LOG_MAX_ADDR-1:0] r_addr_r, r_addr_w;
   logic [WORD_SIZE-1:0]    r_data_w;
   logic [15:0]             r_gen;

   // Physical word address of an extended (row, col) pair; halo indices wrap so
   // every read stays inside the buffer even when the data is later masked.
   function automatic logic [LOG_MAX_ADDR-1:0] word_addr(input logic [ROW_W-1:0] erow,
                                                         input logic [COL_W-1:0] ecol);
      logic [ROW_W-1:0] prow;
      logic [COL_W-1:0] pcol;
      if (erow == '0)            prow = ROW_LAST;
      else if (erow == ROW_EDGE) prow = '0;
      else                       prow = erow - ROW_ONE;
      if (ecol == '0)            pcol = COL_LAST;
      else if (ecol == COL_EDGE) pcol = '0;
      else                       pcol = ecol - COL_ONE;
      return LOG_MAX_ADDR'(prow) * LOG_MAX_ADDR'(WORDS_PER_ROW) + LOG_MAX_ADDR'(pcol);
   endfunction

   function automatic logic [WORD_SIZE-1:0] life_word(input col_t l, input col_t c,
                                                      input col_t r);
      logic [2:0][WORD_SIZE+1:0] ext;
      logic [3:0]                n;
      logic [WORD_SIZE-1:0]      nxt;
      for (int j = 0; j < 3; j++) ext[j] = {r[j][0], c[j], l[j][WORD_SIZE-1]};
      for (int i = 0; i < WORD_SIZE; i++) begin
         n = '0;
         for (int j = 0; j < 3; j++)
            for (int d = 0; d < 3; d++)
               if (!(j == 1 && d == 1)) n = n + 4'(ext[j][i+d]);
         nxt[i] = (n == 4'd3) | (c[1][i] & (n == 4'd2));
      end
      return nxt;
   endfunction

   // NOTE: every variable gets a default before the case so no latch can be inferred.
   always_comb begin
      w_next_state = r_state;
      w_next_phase = r_phase;
      w_next_row   = r_row;
      w_next_col   = r_col;
      case (r_state)
         S_IDLE: begin
            if (start_in && ready_in) begin
               w_next_state = S_ISSUE;
               w_next_phase = '0;
               w_next_row   = '0;
               w_next_col   = '0;
            end
         end
         S_ISSUE: begin
            if (r_phase == PH_ISSUE_LAST) begin
               w_next_state = S_WAIT;
               w_next_phase = '0;
            end else begin
               w_next_phase = r_phase + PH_ONE;
            end
         end
         S_WAIT: begin
            if (r_phase == PH_WAIT_LAST) begin
               w_next_state = S_WRITE;
               w_next_phase = '0;
            end else begin
               w_next_phase = r_phase + PH_ONE;
            end
         end
         S_WRITE: begin
            w_next_phase = '0;
            if (r_col != COL_EDGE) begin
               w_next_state = S_ISSUE;
               w_next_col   = r_col + COL_ONE;
            end else if (r_row != ROW_LAST) begin
               w_next_state = S_ISSUE;
               w_next_row   = r_row + ROW_ONE;
               w_next_col   = '0;
            end else begin
               w_next_state = S_SWAP;
            end
         end
         S_SWAP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see the
   // pre-edge values of each other, independent of statement order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state  <= S_IDLE;
         r_phase  <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_addr_r <= '0;
         r_gen    <= '0;
      end else begin
         r_state <= w_next_state;
         r_phase <= w_next_phase;
         r_row   <= w_next_row;
         r_col   <= w_next_col;
         if (w_next_state == S_ISSUE)
            r_addr_r <= word_addr(w_next_row + ROW_W'(w_next_phase), w_next_col);
         if (w_next_state == S_SWAP)
            r_gen <= r_gen + 16'd1;
      end
   end

   // Each issued read carries its row slot down a pipe as deep as the RAM latency,
   // so the returning word is captured in exactly the cycle it becomes valid.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_tag_vld  <= '0;
         r_tag_slot <= '0;
      end else begin
         r_tag_vld[0]  <= (r_state == S_ISSUE);
         r_tag_slot[0] <= r_phase[1:0];
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_tag_vld[i]  <= r_tag_vld[i-1];
            r_tag_slot[i] <= r_tag_slot[i-1];
         end
      end
   end

   assign w_cap_vld  = r_tag_vld[READ_LATENCY-1];
   assign w_cap_slot = r_tag_slot[READ_LATENCY-1];
   assign w_shift    = w_cap_vld && (w_cap_slot == 2'd2);

`ifdef LIFE_WRAP_EN
   assign w_cap_word = logic_data_r;
`else
   logic [ROW_W-1:0] w_cap_erow;
   logic             w_cap_off;
   assign w_cap_erow = r_row + ROW_W'(w_cap_slot);
   assign w_cap_off  = (w_cap_erow == '0) || (w_cap_erow == ROW_EDGE) ||
                       (r_col == '0) || (r_col == COL_EDGE);
   assign w_cap_word = w_cap_off ? '0 : logic_data_r;
`endif

   always_comb begin
      w_new_col    = '0;
      w_new_col[0] = r_colbuf0;
      w_new_col[1] = r_colbuf1;
      w_new_col[2] = w_cap_word;
   end

   // The left column is only consumed at the shift itself, so only the centre and
   // right columns are stored; the shift edge sees L=r_win_c, C=r_win_r, R=new.
   // NOTE: the window is a few flops, not a RAM, so it is cleared by reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_colbuf0 <= '0;
         r_colbuf1 <= '0;
         r_win_c   <= '0;
         r_win_r   <= '0;
         r_addr_w  <= '0;
         r_data_w  <= '0;
      end else if (w_cap_vld) begin
         case (w_cap_slot)
            2'd0:    r_colbuf0 <= w_cap_word;
            2'd1:    r_colbuf1 <= w_cap_word;
            default: begin
               r_win_c <= r_win_r;
               r_win_r <= w_new_col;
            end
         endcase
         if (w_shift && (r_col >= COL_FIRST_WR)) begin
            r_data_w <= life_word(r_win_c, r_win_r, w_new_col);
            r_addr_w <= word_addr(r_row + ROW_ONE, r_col - COL_ONE);
         end
      end
   end

   assign logic_addr_r  = r_addr_r;
   assign logic_addr_w  = r_addr_w;
   assign logic_data_w  = r_data_w;
   assign logic_wr_en   = (r_state == S_WRITE) && (r_col >= COL_FIRST_WR);
   assign swap_out      = (r_state == S_SWAP);
   assign busy_out      = (r_state != S_IDLE);
   assign gen_count_out = r_gen;

endmodule

// File: tb/tb_life_stepper.sv
// Bench for life_stepper on a 16x4 grid (8-bit words, 2 words per row) with a
// two-bank double buffer model of read latency 2.
module tb_life_stepper;

   localparam int WS = 8;
   localparam int W  = 2;
   localparam int H  = 4;
   localparam int RL = 2;
   localparam int LA = 4;
   localparam int NWORDS = W * H;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          start_in = 1'b0;
   logic          ready_in = 1'b1;
   logic [LA-1:0] logic_addr_r, logic_addr_w;
   logic [WS-1:0] logic_data_r, logic_data_w;
   logic          logic_wr_en, swap_out, busy_out;
   logic [15:0]   gen_count_out;

   life_stepper #(
      .WORD_SIZE(WS), .WORDS_PER_ROW(W), .NUM_ROWS(H),
      .READ_LATENCY(RL), .LOG_MAX_ADDR(LA)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .ready_in(ready_in),
      .logic_addr_r(logic_addr_r), .logic_data_r(logic_data_r),
      .logic_addr_w(logic_addr_w), .logic_data_w(logic_data_w),
      .logic_wr_en(logic_wr_en), .swap_out(swap_out), .busy_out(busy_out),
      .gen_count_out(gen_count_out)
   );

   always #5 clk_in = ~clk_in;

   // Double buffer: logic side reads bank[sel], writes bank[!sel], swap flips sel.
   logic [WS-1:0] bank [2][NWORDS];
   logic          sel = 1'b0;
   logic [WS-1:0] rd1 = '0, rd2 = '0;
   logic          load_req = 1'b0;
   logic [63:0]   load_img = '0;
   int            addr_viol = 0;

   assign logic_data_r = rd2;

   always @(posedge clk_in) begin
      rd1 <= bank[sel][logic_addr_r[2:0]];
      rd2 <= rd1;
      if (load_req) begin
         for (int a = 0; a < NWORDS; a++) begin
            bank[sel][a]  <= load_img[a*8 +: 8];
            bank[!sel][a] <= 8'hA5;
         end
      end else begin
         if (logic_wr_en) bank[!sel][logic_addr_w[2:0]] <= logic_data_w;
         if (swap_out)    sel <= !sel;
      end
      if ((int'(logic_addr_r) >= NWORDS) || (logic_wr_en && int'(logic_addr_w) >= NWORDS))
         addr_viol <= addr_viol + 1;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] read_img();
      logic [63:0] img;
      for (int a = 0; a < NWORDS; a++) img[a*8 +: 8] = bank[sel][a];
      return img;
   endfunction

   task automatic do_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0;
      start_in = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   task automatic load(input logic [63:0] img);
      @(negedge clk_in);
      load_img = img;
      load_req = 1'b1;
      @(negedge clk_in);
      load_req = 1'b0;
   endtask

   // Cycle 1 is the cycle after the edge that samples start_in.
   task automatic run_step(output int swap_cyc, output int n_wr, output logic busy1);
      @(negedge clk_in);
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      swap_cyc = -1;
      n_wr     = 0;
      busy1    = busy_out;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (logic_wr_en) n_wr++;
         if (swap_out) begin
            swap_cyc = cyc;
            break;
         end
         @(posedge clk_in);
         #1;
      end
      @(posedge clk_in);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [63:0] init;
      int          steps;
      logic [63:0] exp;
      logic [15:0] exp_gen;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs [NV];

   initial begin
      int          sc, nw, tot_wr, swaps, first_sw;
      logic        b1;

      vecs[0] = '{"blinker",   64'h0000_0000_00E0_0000, 1, 64'h0000_0040_0040_0040, 16'd1};
      vecs[1] = '{"blinker2",  64'h0000_0000_00E0_0000, 2, 64'h0000_0000_00E0_0000, 16'd2};
      vecs[2] = '{"block",     64'h0000_0180_0180_0000, 3, 64'h0000_0180_0180_0000, 16'd3};
`ifdef LIFE_WRAP_EN
      vecs[3] = '{"edge",      64'h0001_0001_0001_0000, 1, 64'h0000_8003_0000_0000, 16'd1};
      vecs[4] = '{"full",      64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0000_0000_0000_0000, 16'd1};
`else
      vecs[3] = '{"edge",      64'h0001_0001_0001_0000, 1, 64'h0000_0003_0000_0000, 16'd1};
      vecs[4] = '{"full",      64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8001_0000_0000_8001, 16'd1};
`endif

      // Reset state.
      repeat (2) @(posedge clk_in);
      #1;
      check("rst/addr_r",  64'(logic_addr_r),  64'd0);
      check("rst/addr_w",  64'(logic_addr_w),  64'd0);
      check("rst/data_w",  64'(logic_data_w),  64'd0);
      check("rst/wr_en",   64'(logic_wr_en),   64'd0);
      check("rst/swap",    64'(swap_out),      64'd0);
      check("rst/busy",    64'(busy_out),      64'd0);
      check("rst/gen",     64'(gen_count_out), 64'd0);

      for (int v = 0; v < NV; v++) begin
         do_reset();
         load(vecs[v].init);
         tot_wr = 0;
         sc     = -1;
         b1     = 1'b0;
         for (int s = 0; s < vecs[v].steps; s++) begin
            run_step(sc, nw, b1);
            tot_wr += nw;
         end
         check({vecs[v].name, "/image"},     read_img(),            vecs[v].exp);
         check({vecs[v].name, "/gen"},       64'(gen_count_out),    64'(vecs[v].exp_gen));
         check({vecs[v].name, "/swap_cyc"},  64'(sc),               64'd97);
         check({vecs[v].name, "/writes"},    64'(tot_wr),           64'(8 * vecs[v].steps));
         check({vecs[v].name, "/busy_c1"},   64'(b1),               64'd1);
         check({vecs[v].name, "/busy_end"},  64'(busy_out),         64'd0);
         check({vecs[v].name, "/addr_w_hold"}, 64'(logic_addr_w),   64'd7);
      end

      // ready_in low blocks start.
      @(negedge clk_in);
      ready_in = 1'b0;
      start_in = 1'b1;
      swaps    = 0;
      b1       = 1'b0;
      repeat (6) begin
         @(posedge clk_in);
         #1;
         if (busy_out) b1 = 1'b1;
         if (swap_out) swaps++;
      end
      check("ready0/busy",  64'(b1),            64'd0);
      check("ready0/swaps", 64'(swaps),         64'd0);
      check("ready0/gen",   64'(gen_count_out), 64'd1);

      // start_in held high through a whole step: exactly one swap, at cycle 97.
      @(negedge clk_in);
      ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      swaps    = 0;
      first_sw = -1;
      for (int cyc = 1; cyc <= 110; cyc++) begin
         if (swap_out) begin
            swaps++;
            if (first_sw < 0) first_sw = cyc;
         end
         if (cyc == 97) start_in = 1'b0;
         @(posedge clk_in);
         #1;
      end
      check("held/swaps",    64'(swaps),         64'd1);
      check("held/swap_cyc", 64'(first_sw),      64'd97);
      check("held/gen",      64'(gen_count_out), 64'd2);
      check("held/busy_end", 64'(busy_out),      64'd0);

      // Reset asserted mid-step at cycle 40.
      load(64'h0000_0000_00E0_0000);
      @(negedge clk_in);
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      for (int cyc = 1; cyc < 40; cyc++) begin
         @(posedge clk_in);
         #1;
      end
      check("midrst/busy_before", 64'(busy_out), 64'd1);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("midrst/wr_en", 64'(logic_wr_en),   64'd0);
      check("midrst/swap",  64'(swap_out),      64'd0);
      check("midrst/busy",  64'(busy_out),      64'd0);
      check("midrst/gen",   64'(gen_count_out), 64'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      load(64'h0000_0000_00E0_0000);
      run_step(sc, nw, b1);
      check("after_rst/swap_cyc", 64'(sc),            64'd97);
      check("after_rst/writes",   64'(nw),            64'd8);
      check("after_rst/gen",      64'(gen_count_out), 64'd1);
      check("after_rst/image",    read_img(),         64'h0000_0040_0040_0040);

      check("addr_range", 64'(addr_viol), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
